// File: rtl/queue_pkg.sv
// Shared definitions for the BRAM FIFO queue and its pop-side reader.
package queue_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_RD_LATENCY = 2;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StWait,
    StCapture,
    StHold,
    StGuard
  } reader_state_e;

  // Width of a down-counter that must hold lat-1.
  function automatic int unsigned lat_cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/queue_reader_if.sv
// Queue-side strobes/data and downstream valid/ready stream of the queue reader.
// peek_req/m_peek exist only when QUEUE_READER_PEEK_EN is defined.
interface queue_reader_if
  import queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  q_empty;
  logic [DATA_WIDTH-1:0] q_rd_val;
  logic                  q_pop;
  logic                  q_peek;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
`ifdef QUEUE_READER_PEEK_EN
  logic                  peek_req;
  logic                  m_peek;

  modport master (
    input  q_empty, q_rd_val, m_ready, peek_req,
    output q_pop, q_peek, m_data, m_valid, m_peek
  );

  modport slave (
    output q_empty, q_rd_val, m_ready, peek_req,
    input  q_pop, q_peek, m_data, m_valid, m_peek
  );
`else
  modport master (
    input  q_empty, q_rd_val, m_ready,
    output q_pop, q_peek, m_data, m_valid
  );

  modport slave (
    output q_empty, q_rd_val, m_ready,
    input  q_pop, q_peek, m_data, m_valid
  );
`endif

endinterface

// File: rtl/queue_reader.sv
// Pop-side controller for the BRAM FIFO queue: one word per pop, presented on a valid/ready stream.
// Optional peek path enabled by QUEUE_READER_PEEK_EN.
module queue_reader
  import queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned RD_LATENCY = DEFAULT_RD_LATENCY,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  queue_reader_if.master       bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] drained
);

  localparam int unsigned     LatW    = lat_cnt_width(RD_LATENCY);
  localparam logic [LatW-1:0] LatLoad = LatW'(RD_LATENCY - 1);

  reader_state_e         state_q;
  logic [LatW-1:0]       lat_q;
  logic                  pop_q;
  logic                  peek_q;
  logic                  valid_q;
  logic                  word_peek_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  drained_q;
  logic                  start_peek;

`ifdef QUEUE_READER_PEEK_EN
  assign start_peek = bus.peek_req & ~bus.q_empty;
  assign bus.m_peek = word_peek_q & valid_q;
`else
  assign start_peek = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      lat_q       <= '0;
      pop_q       <= 1'b0;
      peek_q      <= 1'b0;
      valid_q     <= 1'b0;
      word_peek_q <= 1'b0;
      data_q      <= '0;
      drained_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Peek wins over pop; q_empty is only trusted here, after the guard cycle.
          if (start_peek) begin
            peek_q      <= 1'b1;
            word_peek_q <= 1'b1;
            state_q     <= StPop;
          end else if (en && !bus.q_empty) begin
            pop_q       <= 1'b1;
            word_peek_q <= 1'b0;
            state_q     <= StPop;
          end
        end
        StPop: begin
          pop_q   <= 1'b0;
          peek_q  <= 1'b0;
          lat_q   <= LatLoad;
          state_q <= StWait;
        end
        StWait: begin
          if (lat_q == '0) begin
            state_q <= StCapture;
          end else begin
            lat_q <= lat_q - LatW'(1);
          end
        end
        StCapture: begin
          data_q  <= bus.q_rd_val;
          valid_q <= 1'b1;
          state_q <= StHold;
        end
        StHold: begin
          if (bus.m_ready) begin
            valid_q <= 1'b0;
            if (!word_peek_q) begin
              drained_q <= drained_q + CNT_WIDTH'(1);
            end
            state_q <= StGuard;
          end
        end
        StGuard: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.q_pop   = pop_q;
  assign bus.q_peek  = peek_q;
  assign bus.m_data  = data_q;
  assign bus.m_valid = valid_q;
  assign busy        = (state_q != StIdle);
  assign drained     = drained_q;

endmodule
